// File: rtl/sdram_init_if.sv
// Command/address bundle between the SDRAM init sequencer and the SDRAM top's
// command mux; the sequencer is the master and drives the SDRAM-side signals.
interface sdram_init_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int BA_WIDTH   = 2
);
  logic                  init_req;
  logic [3:0]            sdram_cmd;
  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic [BA_WIDTH-1:0]   sdram_ba;
  logic                  init_end;

  modport master (
    input  init_req,
    output sdram_cmd,
    output sdram_addr,
    output sdram_ba,
    output init_end
  );

  modport slave (
    output init_req,
    input  sdram_cmd,
    input  sdram_addr,
    input  sdram_ba,
    input  init_end
  );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation: power-up wait, PRECHARGE ALL, REF_NUM AUTO
// REFRESH, MODE REGISTER SET, with programmable spacing; re-runnable on init_req.
module sdram_init_seq #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    BA_WIDTH   = 2,
  parameter int                    T_POWERUP  = 10000,
  parameter int                    T_RP       = 2,
  parameter int                    T_RC       = 4,
  parameter int                    T_MRD      = 2,
  parameter int                    REF_NUM    = 8,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG   = ADDR_WIDTH'('b0000_0011_0010)
) (
  input  logic          clk,
  input  logic          rst_n,
  sdram_init_if.master  bus
);

  localparam int T_MAX_A = (T_POWERUP > T_RP)  ? T_POWERUP : T_RP;
  localparam int T_MAX_B = (T_RC      > T_MRD) ? T_RC      : T_MRD;
  localparam int T_MAX   = (T_MAX_A   > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int REF_W   = $clog2(REF_NUM + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_POWERUP);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RC_LAST  = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] MRD_LAST = CNT_W'(T_MRD - 1);
  localparam logic [REF_W-1:0] REF_TOTAL = REF_W'(REF_NUM);

  localparam logic [ADDR_WIDTH-1:0] ADDR_A10 = ADDR_WIDTH'(1024);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  generate
    if (ADDR_WIDTH < 11 || BA_WIDTH < 1 || T_POWERUP < 1 || T_RP < 1 ||
        T_RC < 1 || T_MRD < 1 || REF_NUM < 1) begin : g_bad_params
      $error("sdram_init_seq: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RC,
    S_MRS,
    S_WAIT_MRD,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REF_W-1:0]      ref_cnt_q;
  logic [3:0]            cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  init_end_q;

  logic [CNT_W-1:0]      gap_last;
  logic                  gap_done;
  logic                  ref_more;

  // cnt_q is 0 while a command is on the bus, so a 1-cycle spacing (last = 0)
  // completes in the command state itself and the wait state is never entered.
  always_comb begin
    gap_last = PWR_LAST;
    case (state_q)
      S_PRE, S_WAIT_RP:  gap_last = RP_LAST;
      S_REF, S_WAIT_RC:  gap_last = RC_LAST;
      S_MRS, S_WAIT_MRD: gap_last = MRD_LAST;
      default:           gap_last = PWR_LAST;
    endcase
  end

  assign gap_done = (cnt_q == gap_last);
  assign ref_more = (ref_cnt_q < REF_TOTAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_PWR;
      cnt_q      <= '0;
      ref_cnt_q  <= '0;
      cmd_q      <= CMD_NOP;
      addr_q     <= ADDR_A10;
      init_end_q <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      addr_q <= ADDR_A10;
      case (state_q)
        S_WAIT_PWR: begin
          if (gap_done) begin
            state_q <= S_PRE;
            cmd_q   <= CMD_PRE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRE, S_WAIT_RP: begin
          if (gap_done) begin
            state_q   <= S_REF;
            cmd_q     <= CMD_AREF;
            ref_cnt_q <= ref_cnt_q + 1'b1;
            cnt_q     <= '0;
          end else begin
            state_q <= S_WAIT_RP;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_REF, S_WAIT_RC: begin
          if (gap_done) begin
            cnt_q <= '0;
            if (ref_more) begin
              state_q   <= S_REF;
              cmd_q     <= CMD_AREF;
              ref_cnt_q <= ref_cnt_q + 1'b1;
            end else begin
              state_q <= S_MRS;
              cmd_q   <= CMD_MRS;
              addr_q  <= MODE_REG;
            end
          end else begin
            state_q <= S_WAIT_RC;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_MRS, S_WAIT_MRD: begin
          if (gap_done) begin
            state_q    <= S_DONE;
            init_end_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
            state_q <= S_WAIT_MRD;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Re-init skips the power-up wait and restarts at PRECHARGE.
          if (bus.init_req) begin
            state_q    <= S_PRE;
            cmd_q      <= CMD_PRE;
            init_end_q <= 1'b0;
            ref_cnt_q  <= '0;
          end
        end
        default: state_q <= S_WAIT_PWR;
      endcase
    end
  end

  assign bus.sdram_cmd  = cmd_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_ba   = {BA_WIDTH{1'b0}};
  assign bus.init_end   = init_end_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: three configurations, directed and
// random init_req / reset stimulus, events predicted from the timing rules.
module tb_sdram_init_seq;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  PRE  = 4'b0010;
  localparam logic [3:0]  AREF = 4'b0001;
  localparam logic [3:0]  MRS  = 4'b0000;
  localparam logic [12:0] A10  = 13'h0400;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [12:0] addr;
    logic       end_v;
  } ev_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic init_req = 1'b0;

  int sel         = 0;
  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int done_cyc    = 32'h7fffffff;

  ev_t  exp_q[$];
  ev_t  got_e;
  logic prev_end = 1'b0;

  int          cfg_pwr [3] = '{10000, 5, 20};
  int          cfg_rp  [3] = '{2, 1, 3};
  int          cfg_rc  [3] = '{4, 1, 5};
  int          cfg_mrd [3] = '{2, 1, 4};
  int          cfg_ref [3] = '{8, 2, 3};
  logic [12:0] cfg_mode[3] = '{13'h0032, 13'h0032, 13'h0027};

  always #5 clk = ~clk;

  sdram_init_if #(.ADDR_WIDTH(12), .BA_WIDTH(2)) if0 ();
  sdram_init_if #(.ADDR_WIDTH(12), .BA_WIDTH(2)) if1 ();
  sdram_init_if #(.ADDR_WIDTH(13), .BA_WIDTH(2)) if2 ();

  assign if0.init_req = init_req;
  assign if1.init_req = init_req;
  assign if2.init_req = init_req;

  sdram_init_seq u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  sdram_init_seq #(
    .T_POWERUP (5),
    .T_RP      (1),
    .T_RC      (1),
    .T_MRD     (1),
    .REF_NUM   (2)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  sdram_init_seq #(
    .ADDR_WIDTH (13),
    .T_POWERUP  (20),
    .T_RP       (3),
    .T_RC       (5),
    .T_MRD      (4),
    .REF_NUM    (3),
    .MODE_REG   (13'h0027)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  logic [3:0]  m_cmd;
  logic [12:0] m_addr;
  logic [1:0]  m_ba;
  logic        m_end;

  always_comb begin
    m_cmd  = if0.sdram_cmd;
    m_addr = {1'b0, if0.sdram_addr};
    m_ba   = if0.sdram_ba;
    m_end  = if0.init_end;
    if (sel == 1) begin
      m_cmd  = if1.sdram_cmd;
      m_addr = {1'b0, if1.sdram_addr};
      m_ba   = if1.sdram_ba;
      m_end  = if1.init_end;
    end else if (sel == 2) begin
      m_cmd  = if2.sdram_cmd;
      m_addr = if2.sdram_addr;
      m_ba   = if2.sdram_ba;
      m_end  = if2.init_end;
    end
  end

  // Cycle 1 is the first rising edge after reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic string cmd_name(logic [3:0] c);
    case (c)
      NOP:     return "NOP";
      PRE:     return "PRE";
      AREF:    return "AREF";
      MRS:     return "MRS";
      default: return "???";
    endcase
  endfunction

  // Monitor: every command or init_end change is a transaction popped from the queue.
  always @(negedge clk) begin
    vectors++;
    if (!rst_n) begin
      if (m_cmd !== NOP || m_addr !== A10 || m_ba !== 2'b00 || m_end !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cfg%0d: got cmd=%b addr=%h ba=%0d end=%b, want cmd=%b addr=%h ba=0 end=0",
                 sel, m_cmd, m_addr, m_ba, m_end, NOP, A10);
      end
      prev_end = 1'b0;
    end else if (m_cmd !== NOP || m_end !== prev_end) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cfg%0d cycle %0d: got cmd=%s addr=%h end=%b, want no event",
                 sel, cyc, cmd_name(m_cmd), m_addr, m_end);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.cyc != cyc || got_e.cmd !== m_cmd || got_e.addr !== m_addr ||
            got_e.end_v !== m_end || m_ba !== 2'b00) begin
          miscompares++;
          $display("FAIL seq_event cfg%0d: got %s addr=%h end=%b ba=%0d at cycle %0d, want %s addr=%h end=%b ba=0 at cycle %0d",
                   sel, cmd_name(m_cmd), m_addr, m_end, m_ba, cyc,
                   cmd_name(got_e.cmd), got_e.addr, got_e.end_v, got_e.cyc);
        end else begin
          $display("[cfg%0d] cycle %0d: %s addr=%h init_end=%b ok",
                   sel, cyc, cmd_name(m_cmd), m_addr, m_end);
        end
      end
      prev_end = m_end;
    end else if (m_addr !== A10 || m_ba !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_bus cfg%0d cycle %0d: got addr=%h ba=%0d, want addr=%h ba=0",
               sel, cyc, m_addr, m_ba, A10);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(int c, logic [3:0] cmd, logic [12:0] addr, logic end_v);
    ev_t e;
    e.cyc   = c;
    e.cmd   = cmd;
    e.addr  = addr;
    e.end_v = end_v;
    exp_q.push_back(e);
  endtask

  // Reference model: absolute cycle of every event of one sequence starting with PRE at 'start'.
  task automatic plan(int start);
    int t;
    push_ev(start, PRE, A10, 1'b0);
    t = start + cfg_rp[sel];
    for (int k = 0; k < cfg_ref[sel]; k++)
      push_ev(t + k * cfg_rc[sel], AREF, A10, 1'b0);
    t = t + cfg_ref[sel] * cfg_rc[sel];
    push_ev(t, MRS, cfg_mode[sel], 1'b0);
    done_cyc = t + cfg_mrd[sel];
    push_ev(done_cyc, NOP, A10, 1'b1);
  endtask

  task automatic do_reset(int hold);
    rst_n    = 1'b0;
    init_req = 1'b0;
    exp_q.delete();
    done_cyc = 32'h7fffffff;
    repeat (hold) tick();
    rst_n = 1'b1;
    plan(cfg_pwr[sel] + 1);
  endtask

  // init_req driven in cycle c is taken at the next edge only if init_end is high in c.
  task automatic pulse(int len);
    for (int i = 0; i < len; i++) begin
      init_req = 1'b1;
      if (cyc >= done_cyc) plan(cyc + 1);
      tick();
    end
    init_req = 1'b0;
  endtask

  task automatic wait_until(int c);
    int guard = 0;
    while (cyc < c && guard < 20000) begin
      tick();
      guard++;
    end
  endtask

  task automatic check_drained(string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d pending events (next due cycle %0d, now %0d), want 0",
               name, exp_q.size(), exp_q[0].cyc, cyc);
    end
  endtask

  task automatic random_run(int iters, int max_gap, string name);
    for (int it = 0; it < iters; it++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      if ($urandom_range(0, 9) < 7) pulse(int'($urandom_range(1, 3)));
      else                          do_reset(int'($urandom_range(1, 4)));
    end
    wait_until(done_cyc + 5);
    check_drained(name);
  endtask

  initial begin
    sel = 0;
    do_reset(3);
    wait_until(10060);
    check_drained("power_up_sequence");

    wait_until(10100);
    pulse(1);
    wait_until(10160);
    check_drained("reinit_sequence");

    do_reset(2);
    wait_until(10010);
    pulse(11);
    wait_until(10060);
    check_drained("req_mid_sequence");

    do_reset(2);
    wait_until(10015);
    do_reset(3);
    wait_until(10060);
    check_drained("reset_mid_sequence");

    sel = 1;
    do_reset(2);
    wait_until(20);
    check_drained("back_to_back");
    random_run(40, 12, "random_cfg1");

    sel = 2;
    do_reset(2);
    random_run(60, 30, "random_cfg2");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
